// File: rtl/led_pkg.sv
// led_pkg: shared mode type, mode sequencing and default parameters for the LED PWM controller
package led_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, STATIC = 2'd1, BREATHE = 2'd2, BLINK = 2'd3} mode_e;
  localparam int DEF_NUM_CH          = 3;
  localparam int DEF_PWM_BITS        = 8;
  localparam int DEF_PRESCALE_BITS   = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 480000;
  localparam bit DEF_ACTIVE_LOW      = 1'b1;
  function automatic mode_e mode_next(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise the raw active-low button, debounce it and pulse once per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, stable, armed, accept;
  logic [1:0] fill;
  logic [CW-1:0] cnt;
  assign accept = (s2 != stable) && (cnt == LAST);
  // armed only once a genuine released level has been seen, so a button held through reset is ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      fill   <= '0;
      armed  <= 1'b0;
      press  <= 1'b0;
    end else begin
      s1     <= btn_n;
      s2     <= s1;
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & s2);
      cnt    <= (s2 == stable || accept) ? '0 : cnt + 1'b1;
      stable <= accept ? s2 : stable;
      press  <= accept & ~s2 & armed;
    end
endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel LED PWM driver with OFF/STATIC/BREATHE/BLINK modes cycled by a debounced button
module led_pwm_ctrl import led_pkg::*; #(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int PRESCALE_BITS   = DEF_PRESCALE_BITS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btn_n,
  input  logic [NUM_CH*PWM_BITS-1:0] duty_i,
  output logic [NUM_CH-1:0]          led_o,
  output logic [1:0]                 mode_o,
  output logic                       btn_press_o
);
  localparam logic [PWM_BITS-1:0] PMAX = '1;
  mode_e mode, mode_d;
  logic press, up, phase, tick, wrap;
  logic [PWM_BITS-1:0] pwm_cnt, level, blink_cnt;
  logic [PRESCALE_BITS-1:0] pre;
  logic [NUM_CH-1:0] lit;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .press(press)
  );
  assign tick        = &pre;
  assign wrap        = &pwm_cnt;
  assign btn_press_o = press;
  assign mode_o      = mode;
  assign led_o       = ACTIVE_LOW ? ~lit : lit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode <= OFF;
    else mode <= mode_d;
  always_comb mode_d = press ? mode_next(mode) : mode;
  // a press outranks a coincident step tick; the PWM counter never restarts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_cnt   <= '0;
      pre       <= '0;
      level     <= '0;
      up        <= 1'b1;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pre     <= pre + 1'b1;
      if (press) begin
        level     <= '0;
        up        <= 1'b1;
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (tick) begin
        if (mode == BREATHE) begin
          up    <= up ? level != PMAX : level == '0;
          level <= up ? (level == PMAX ? level : level + 1'b1) : (level == '0 ? level : level - 1'b1);
        end
        if (mode == BLINK) begin
          blink_cnt <= blink_cnt + 1'b1;
          phase     <= phase ^ (blink_cnt == PMAX);
        end
      end
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PWM_BITS-1:0] d, scaled, eff, dq;
    logic l;
    assign d      = duty_i[c*PWM_BITS +: PWM_BITS];
    assign scaled = PWM_BITS'(({{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, level}) >> PWM_BITS);
    assign lit[c] = l;
    always_comb eff = mode == STATIC ? d : mode == BREATHE ? scaled : (mode == BLINK && phase) ? d : '0;
    // duty only reloads at the end of a period so a period never mixes two duties
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        dq <= '0;
        l  <= 1'b0;
      end else begin
        dq <= wrap ? eff : dq;
        l  <= pwm_cnt < dq;
      end
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: table-driven, directed and randomized checks of led_pwm_ctrl against a behavioural model
module tb_led_pwm_ctrl;
  localparam int NC = 3, PB = 4, PS = 2, DB = 4, M = 1 << PB, P = 1 << PS;
  typedef struct packed {
    logic [NC-1:0][PB-1:0] duty;
    logic [NC-1:0][PB:0]   low;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, btn_n = 1'b1;
  logic [NC*PB-1:0] duty_i = '0;
  logic [NC-1:0] led_o;
  logic [1:0] mode_o;
  logic btn_press_o;
  int tests = 0, fails = 0, shown = 0, pulses = 0;
  int cyc = 0, nt = 0, m_mode = 0;
  bit m_press = 0, stable = 1, armed = 0;
  bit [NC-1:0] m_lit = '0;
  int dq[NC] = '{default: 0};
  bit win[$];
  bit pipe[$] = '{1'b1, 1'b1};

  led_pwm_ctrl #(.NUM_CH(NC), .PWM_BITS(PB), .PRESCALE_BITS(PS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .duty_i(duty_i),
    .led_o(led_o), .mode_o(mode_o), .btn_press_o(btn_press_o)
  );

  always #5 clk = ~clk;

  // triangle wave: 0..M-1, held one tick at the top, back down to 0, held one tick
  function automatic int lvl(int n);
    int p;
    p = n % (2 * M);
    return p < M ? p : 2 * M - 1 - p;
  endfunction

  function automatic int eff(int d);
    if (m_mode == 1) return d;
    if (m_mode == 2) return (d * lvl(nt)) >> PB;
    if (m_mode == 3 && (nt / M) % 2 == 1) return d;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; nt = 0; m_mode = 0; m_press = 0; stable = 1; armed = 0; m_lit = '0;
      for (int i = 0; i < NC; i++) dq[i] = 0;
      win.delete();
      pipe = '{1'b1, 1'b1};
    end else begin : mdl
      int pc;
      bit s2, flip;
      pc = cyc % M;
      for (int i = 0; i < NC; i++) m_lit[i] = pc < dq[i];
      if (pc == M - 1) for (int i = 0; i < NC; i++) dq[i] = eff(int'(duty_i[i*PB +: PB]));
      if (m_press) begin
        m_mode = (m_mode + 1) % 4;
        nt = 0;
      end else if (cyc % P == P - 1) nt++;
      s2 = pipe.pop_front();
      pipe.push_back(btn_n);
      win.push_back(s2);
      if (win.size() > DB) void'(win.pop_front());
      flip = win.size() == DB;
      foreach (win[k]) if (win[k] == stable) flip = 0;
      m_press = flip && !s2 && armed;
      if (flip) stable = s2;
      if (cyc >= 2 && s2) armed = 1;
      cyc++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (shown < 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      shown++;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      chk("cycle", {26'd0, led_o, mode_o, btn_press_o}, {26'd0, ~m_lit, 2'(m_mode), m_press});
      if (btn_press_o) pulses++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_btn();
    btn_n = 1'b0;
    step(8);
    btn_n = 1'b1;
    step(8);
  endtask

  initial begin
    vec_t tbl[5];
    int lat, guard;
    int lows[NC];
    tbl[0] = '{duty: {4'd15, 4'd5, 4'd0}, low: {5'd15, 5'd5, 5'd0}};
    tbl[1] = '{duty: {4'd14, 4'd8, 4'd1}, low: {5'd14, 5'd8, 5'd1}};
    tbl[2] = '{duty: {4'd7, 4'd0, 4'd15}, low: {5'd7, 5'd0, 5'd15}};
    tbl[3] = '{duty: {4'd3, 4'd3, 4'd3}, low: {5'd3, 5'd3, 5'd3}};
    tbl[4] = '{duty: {4'd9, 4'd12, 4'd2}, low: {5'd9, 5'd12, 5'd2}};
    duty_i = tbl[0].duty;
    step(3);
    rst_n = 1'b1;
    step(20);
    chk("reset_led", 32'(led_o), 32'h7);
    chk("reset_mode", 32'(mode_o), 32'h0);
    // short glitch must not register
    pulses = 0;
    btn_n = 1'b0;
    step(3);
    btn_n = 1'b1;
    step(12);
    chk("glitch_no_press", pulses, 0);
    // press latency from the btn_n edge
    lat = -1;
    btn_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (lat < 0 && btn_press_o) lat = k;
    end
    chk("press_latency", lat, 6);
    btn_n = 1'b1;
    step(10);
    chk("mode_after_press", 32'(mode_o), 32'h1);
    // STATIC duty table
    for (int i = 0; i < 5; i++) begin
      duty_i = tbl[i].duty;
      step(2 * M);
      for (int c = 0; c < NC; c++) lows[c] = 0;
      for (int s = 0; s < M; s++) begin
        step(1);
        for (int c = 0; c < NC; c++) lows[c] += int'(!led_o[c]);
      end
      for (int c = 0; c < NC; c++) chk("static_low", lows[c], int'(tbl[i].low[c]));
    end
    // duty change mid-period
    duty_i = tbl[0].duty;
    step(2 * M);
    guard = 0;
    while (cyc % M != 8 && guard < 2 * M) begin step(1); guard++; end
    duty_i[PB +: PB] = 4'd8;
    step(3 * M);
    // BREATHE with full duty, then BLINK with ch0 = 10
    duty_i = {NC{4'd15}};
    press_btn();
    chk("enter_breathe", 32'(mode_o), 32'h2);
    step(300);
    duty_i = {4'd0, 4'd0, 4'd10};
    press_btn();
    chk("enter_blink", 32'(mode_o), 32'h3);
    step(300);
    // press landing on a step tick while in BREATHE
    guard = 0;
    while (m_mode != 2 && guard < 6) begin press_btn(); guard++; end
    duty_i = {NC{4'd15}};
    step(40);
    guard = 0;
    while (cyc % P != 1 && guard < 2 * P) begin step(1); guard++; end
    press_btn();
    chk("coincident_mode", 32'(mode_o), 32'h3);
    step(150);
    // presses at every prescaler alignment
    for (int k = 0; k < P; k++) begin
      guard = 0;
      while (cyc % P != k && guard < 2 * P) begin step(1); guard++; end
      press_btn();
      step(40);
    end
    // randomized button activity and duty changes
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) duty_i = (NC*PB)'($urandom);
      btn_n = 1'($urandom_range(0, 1));
      step($urandom_range(1, 12));
    end
    btn_n = 1'b1;
    step(10);
    // asynchronous reset mid-operation, button held through release
    guard = 0;
    while (m_mode != 1 && guard < 6) begin press_btn(); guard++; end
    duty_i = {NC{4'd12}};
    step(2 * M + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", 32'(led_o), 32'h7);
    chk("async_mode", 32'(mode_o), 32'h0);
    chk("async_press", 32'(btn_press_o), 32'h0);
    btn_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    pulses = 0;
    step(20);
    chk("held_no_press", pulses, 0);
    chk("held_mode", 32'(mode_o), 32'h0);
    btn_n = 1'b1;
    step(10);
    press_btn();
    chk("repress_mode", 32'(mode_o), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
